// File: rtl/sub_serial_if.sv
// sub_serial_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//   master : requester side (drives start/a/b/bin, observes busy/done/diff/bout)
//   slave  : subtractor side
//   start  request pulse or level; sampled only when the subtractor is idle/done
//   a, b   minuend / subtractor operands (WIDTH bits)
//   bin    borrow in
//   busy   high while bits are being shifted
//   done   one-cycle completion pulse
//   diff   (a - b - bin) mod 2^WIDTH, held between operations
//   bout   borrow out, 1 iff a < b + bin (unsigned)
interface sub_serial_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/sub_serial.sv
// sub_serial
//   Bit-serial subtractor computing a - b - bin, one bit per clock, LSB first,
//   through a single full-subtractor cell and a borrow flip-flop.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    sub_serial_if.slave: start/a/b/bin in, busy/done/diff/bout out
//   Latency start->done is WIDTH+1 cycles; start held during the done cycle
//   is accepted immediately for back-to-back operation.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    sub_serial_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // One full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fsub_bit(input logic x, input logic y, input logic bi);
        fsub_bit = {(~x & y) | (~(x ^ y) & bi), x ^ y ^ bi};
    endfunction

    state_t           r_state;
    logic [WIDTH-1:0] r_ra;
    logic [WIDTH-1:0] r_rb;
    logic [WIDTH-1:0] r_acc;
    logic             r_brw;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic [1:0]       w_fs;
    logic             w_d;
    logic             w_brw_nxt;
    logic             w_accept;

    assign w_fs      = fsub_bit(r_ra[0], r_rb[0], r_brw);
    assign w_d       = w_fs[0];
    assign w_brw_nxt = w_fs[1];
    assign w_accept  = bus.start && (r_state != S_RUN);

    // Operand and partial-result shift registers carry no reset: they are
    // always reloaded on acceptance and fully overwritten before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ra <= bus.a;
            r_rb <= bus.b;
        end else if (r_state == S_RUN) begin
            r_ra  <= r_ra >> 1;
            r_rb  <= r_rb >> 1;
            r_acc <= {w_d, r_acc[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
            r_cnt   <= '0;
            r_brw   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_brw   <= bus.bin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_brw <= w_brw_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // Final bit goes straight into diff so the result
                        // appears on the same edge that ends RUN.
                        r_diff  <= {w_d, r_acc[WIDTH-1:1]};
                        r_bout  <= w_brw_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.diff = r_diff;
    assign bus.bout = r_bout;

endmodule

// File: tb/tb_sub_serial.sv
module tb_sub_serial;

    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    logic [W-1:0] prev_diff;
    logic         prev_bout;

    sub_serial_if #(.WIDTH(W)) intf ();

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one operation from a negedge. With full=1 every RUN cycle is
    // checked for busy/done and held diff; the done cycle is always checked.
    // Returns at the negedge inside the done cycle.
    task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, input logic [W-1:0] ediff, input logic ebout,
                         input bit full);
        @(negedge clk);
        intf.a = ta; intf.b = tb; intf.bin = tbin; intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge clk);
            if (full) begin
                check({tag, "_busy"},      32'(intf.busy), 32'd1);
                check({tag, "_nodone"},    32'(intf.done), 32'd0);
                check({tag, "_diff_held"}, 32'(intf.diff), 32'(prev_diff));
            end
        end
        @(negedge clk);
        check({tag, "_done"}, 32'(intf.done), 32'd1);
        check({tag, "_idle"}, 32'(intf.busy), 32'd0);
        check({tag, "_diff"}, 32'(intf.diff), 32'(ediff));
        check({tag, "_bout"}, 32'(intf.bout), 32'(ebout));
        prev_diff = ediff;
        prev_bout = ebout;
    endtask

    initial begin
        int ndone;
        logic [W:0] m;
        n_pass = 0; n_total = 0;
        intf.start = 1'b0; intf.a = '0; intf.b = '0; intf.bin = 1'b0;
        prev_diff = '0; prev_bout = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(intf.busy), 32'd0);
        check("rst_done", 32'(intf.done), 32'd0);
        check("rst_diff", 32'(intf.diff), 32'd0);
        check("rst_bout", 32'(intf.bout), 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        do_op("t1", 4'b0110, 4'b0011, 1'b0, 4'b0011, 1'b0, 1'b1);
        @(negedge clk);
        check("t1_done_one_cycle", 32'(intf.done), 32'd0);
        do_op("t2", 4'b0011, 4'b0110, 1'b0, 4'b1101, 1'b1, 1'b1);
        do_op("t3", 4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b1);
        do_op("t4", 4'b1111, 4'b0001, 1'b1, 4'b1101, 1'b0, 1'b1);

        // Operand change and start pulse during RUN: 1001 - 0100 = 0101
        @(negedge clk);
        intf.a = 4'b1001; intf.b = 4'b0100; intf.bin = 1'b0; intf.start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) intf.start = 1'b0;
            if (i == 2) begin intf.a = 4'b1111; intf.b = 4'b1111; intf.start = 1'b1; end
            if (i == 3) intf.start = 1'b0;
            if (intf.done) begin
                ndone = ndone + 1;
                check("chg_diff", 32'(intf.diff), 32'h5);
                check("chg_bout", 32'(intf.bout), 32'd0);
            end else if (ndone == 0) begin
                check("chg_diff_held", 32'(intf.diff), 32'(prev_diff));
            end
        end
        check("chg_one_done", 32'(ndone), 32'd1);
        prev_diff = 4'b0101; prev_bout = 1'b0;

        // Reset mid-RUN
        @(negedge clk);
        intf.a = 4'b0011; intf.b = 4'b0110; intf.bin = 1'b0; intf.start = 1'b1;
        @(negedge clk);
        intf.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(intf.busy), 32'd0);
        check("mid_rst_done", 32'(intf.done), 32'd0);
        check("mid_rst_diff", 32'(intf.diff), 32'd0);
        check("mid_rst_bout", 32'(intf.bout), 32'd0);
        @(negedge clk);
        check("mid_rst_no_done", 32'(intf.done), 32'd0);
        rst_n = 1'b1;
        prev_diff = '0; prev_bout = 1'b0;
        do_op("after_rst", 4'b1000, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b1);

        // Back-to-back: 1100-0101=0111 b0, then 0010-0111-1=1010 b1
        @(negedge clk);
        intf.a = 4'b1100; intf.b = 4'b0101; intf.bin = 1'b0; intf.start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin intf.a = 4'b0010; intf.b = 4'b0111; intf.bin = 1'b1; end
            check("b2b_busy", 32'(intf.busy), (i == 5 || i == 10) ? 32'd0 : 32'd1);
            check("b2b_done", 32'(intf.done), (i == 5 || i == 10) ? 32'd1 : 32'd0);
            if (i == 5) begin
                check("b2b_diff1", 32'(intf.diff), 32'h7);
                check("b2b_bout1", 32'(intf.bout), 32'd0);
            end
            if (i == 10) begin
                check("b2b_diff2", 32'(intf.diff), 32'hA);
                check("b2b_bout2", 32'(intf.bout), 32'd1);
                intf.start = 1'b0;
            end
        end
        prev_diff = 4'hA; prev_bout = 1'b1;

        // Exhaustive sweep against (WIDTH+1)-bit two's-complement difference
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    m = {1'b0, 4'(ia)} - {1'b0, 4'(ib)} - 5'(ic);
                    do_op("sweep", 4'(ia), 4'(ib), 1'(ic), m[W-1:0], m[W], 1'b0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sub_serial.md
# sub_serial

Bit-serial subtractor, the arithmetic counterpart of the combinational `add` block in the ArithmeticOps group. It computes `a - b - bin` for WIDTH-bit operands one bit per clock, LSB first, through a single-bit full-subtractor and a borrow flip-flop. It uses a start/busy/done handshake so the step2 datapath sequencer can trade latency for area. Results and port conventions (operands, carry/borrow in and out) mirror `add`, so the two blocks are interchangeable behind the same ALU select.

## Interface
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the block's only clock.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- bin  input  1  borrow in; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- diff  output  WIDTH  result `(a - b - bin) mod 2^WIDTH`; held between operations.
- bout  output  1  borrow out; 1 iff `a < b + bin` (unsigned).

## Operation
- States:
  - IDLE: waiting for `start`.
  - RUN: shifting bits through the subtractor.
  - DONE: result valid for one cycle.
- Internal registers:
  - `ra`, `rb`: WIDTH-bit shift registers, LSB consumed first.
  - `brw`: 1-bit borrow register.
  - `cnt`: bit counter, clog2(WIDTH) bits.
  - `acc`: WIDTH-bit result shift register.
- IDLE or DONE, `start=1`:
  - load `ra=a`, `rb=b`, `brw=bin`, `cnt=0`; go to RUN.
- IDLE, `start=0`: stay in IDLE.
- DONE, `start=0`: go to IDLE.
- RUN, each cycle:
  - d = `ra[0] ^ rb[0] ^ brw`.
  - next brw = `(~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & brw)`.
  - shift `d` into the MSB of `acc`; shift `ra` and `rb` right by one.
  - `cnt` increments.
- RUN with `cnt == WIDTH-1`:
  - `diff` gets the final `acc`, including this cycle's bit.
  - `bout` gets the next brw value.
  - go to DONE.
- `start` during RUN is ignored and has no side effects.
- Changes to `a`, `b`, `bin` after the accepting edge have no effect.
- `diff`/`bout` update only on the completing edge. They never show partial results and hold until the next completion.
- Arithmetic is unsigned modulo 2^WIDTH. `{bout, diff}` equals the two's-complement (WIDTH+1)-bit result of `a - b - bin`.

## Timing
- Reset values (rst_n low, asynchronous): state=IDLE, busy=0, done=0, diff=0, bout=0, cnt=0, brw=0.
- All outputs are registered; there is no combinational path from any input to any output.
- Edge numbering: E0 is the edge that accepts `start`.
  - `busy` is high from after E0 until after E_WIDTH.
  - E_WIDTH is the last RUN edge; `diff`/`bout` are valid after it.
  - `done` is high for exactly the cycle between E_WIDTH and E_WIDTH+1.
- Latency from start to done is WIDTH+1 cycles (5 for WIDTH=4).
- Throughput: `start` held high during the DONE cycle is accepted at E_WIDTH+1. This gives back-to-back operations every WIDTH+1 cycles with no IDLE gap; `busy` rises again immediately.
- `start` held continuously from IDLE yields one operation per WIDTH+1 cycles.
- Reset asserted mid-RUN:
  - operation aborts; no `done` pulse.
  - `diff`/`bout` return to 0.
  - after release the block is in IDLE and accepts `start` on the first edge.
- Reset deasserts synchronously to clk (system-level requirement); the block adds no synchronizer.

## Test plan
- a=0110, b=0011, bin=0, start one cycle -> busy 4 cycles; done pulses at cycle 5; diff=0011, bout=0.
- a=0011, b=0110, bin=0 -> diff=1101, bout=1. Then a=0000, b=0000, bin=1 -> diff=1111, bout=1.
- a=1111, b=0001, bin=1 -> diff=1101, bout=0.
- Operand change and start pulse two cycles into RUN:
  - inputs switched to a=1111, b=1111 after accept -> result still reflects the captured operands.
  - exactly one done pulse.
  - diff unchanged until done.
- Reset mid-operation: rst_n low at cycle 2 of RUN -> busy=0, done=0, diff=0000, bout=0 immediately. A new start after release completes normally.
- Back-to-back: start held high across the DONE cycle -> second operation accepted with no idle cycle, and done pulses at a 5-cycle period. Also an exhaustive sweep of all 512 (a, b, bin) combinations checked against `{bout, diff} == a - b - bin` (WIDTH+1-bit).
